// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// The write-through bypass in regfile_mp is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

   typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_DEPTH = 32;

   // Bit offset of one port's field within a packed multi-port bus.
   function automatic int port_off(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register. Issue sets, write-back clears.
module regfile_scoreboard #(
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic          iss_en,
   input  logic [AW-1:0] iss_rd,
   output logic [DEPTH-1:0] busy_vec
);

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_vec <= '0;
      end else if (run) begin
         for (int i = 0; i < DEPTH; i++) begin
            // A same-cycle issue names a younger producer, so set beats clear.
            if (iss_en && iss_rd == AW'(i) && !(ZERO_REG != 0 && i == 0))
               busy_vec[i] <= 1'b1;
            else if (wr_en && wr_addr == AW'(i))
               busy_vec[i] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with post-reset clear sweep and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = DEF_XLEN,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [XLEN-1:0]        wr_data,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0] rd_data,
   output logic [NUM_RD-1:0]      rd_busy,
   input  logic                   iss_en,
   input  logic [AW-1:0]          iss_rd,
   output logic                   ready,
   output logic [DEPTH-1:0]       busy_vec
);

   rf_state_e       state;
   logic [AW-1:0]   clr_idx;
   logic            run;
   logic            wr_ok;
   logic [XLEN-1:0] mem [DEPTH];

   assign run   = (state == RF_RUN);
   assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RF_INIT;
         clr_idx <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            RF_INIT: begin
               clr_idx <= clr_idx + AW'(1);
               if (clr_idx == AW'(DEPTH - 1)) begin
                  state <= RF_RUN;
                  ready <= 1'b1;
               end
            end
            RF_RUN: ;
         endcase
      end
   end

   // No reset on the array so it can map to distributed RAM; the sweep clears it.
   always_ff @(posedge clk) begin
      if (!run)
         mem[clr_idx] <= '0;
      else if (wr_ok && !reset)
         mem[wr_addr] <= wr_data;
   end

   regfile_scoreboard #(.DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_sb (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .wr_en    (wr_ok),
      .wr_addr  (wr_addr),
      .iss_en   (iss_en),
      .iss_rd   (iss_rd),
      .busy_vec (busy_vec)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic            is_zero;
      logic [XLEN-1:0] d;
      logic            b;

      assign ra      = rd_addr[port_off(i, AW) +: AW];
      assign is_zero = (ZERO_REG != 0) && (ra == '0);

      always_comb begin
         d = '0;
         b = 1'b0;
         if (run && !is_zero) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_en && wr_addr == ra) begin
               d = wr_data;
               b = 1'b0;
            end else
`endif
            begin
               d = mem[ra];
               b = busy_vec[ra];
            end
         end
      end

      assign rd_data[port_off(i, XLEN) +: XLEN] = d;
      assign rd_busy[i] = b;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters) against an array-based model.
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int DEPTH = 32;
   localparam int NRD = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            wr_en = 1'b0;
   logic [4:0]      wr_addr = '0;
   logic [31:0]     wr_data = '0;
   logic [9:0]      rd_addr = '0;
   logic [63:0]     rd_data;
   logic [1:0]      rd_busy;
   logic            iss_en = 1'b0;
   logic [4:0]      iss_rd = '0;
   logic            ready;
   logic [31:0]     busy_vec;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] ref_mem [DEPTH];
   logic [31:0] ref_busy = '0;
   logic        ref_ready = 1'b0;
   int          init_cnt = 0;

   regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NRD), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .iss_en(iss_en), .iss_rd(iss_rd), .ready(ready), .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected read values straight from the architectural rules.
   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (!ref_ready || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == a) return wr_data;
`endif
      return ref_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (!ref_ready || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == a) return 1'b0;
`endif
      return ref_busy[a];
   endfunction

   // Advance one clock edge, updating the model with the inputs the DUT samples.
   task automatic tick();
      if (reset) begin
         ref_ready = 1'b0;
         init_cnt  = 0;
         ref_busy  = '0;
      end else if (!ref_ready) begin
         init_cnt++;
         if (init_cnt == DEPTH) begin
            ref_ready = 1'b1;
            for (int r = 0; r < DEPTH; r++) ref_mem[r] = '0;
         end
      end else begin
         if (wr_en && wr_addr != 0) begin
            ref_mem[wr_addr]  = wr_data;
            ref_busy[wr_addr] = 1'b0;
         end
         if (iss_en && iss_rd != 0) ref_busy[iss_rd] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0;
      iss_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      rd_addr = {5'd7, 5'd3};
      #1;
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready); end
      n_cmp++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL reset_busy_vec got %h want 0", busy_vec); end
      n_cmp++; if (rd_data !== 64'h0) begin n_err++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
      n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL reset_rd_busy got %b want 0", rd_busy); end
   endtask

   task automatic test_init_sweep();
      int zeros;
      zeros = 0;
      reset = 1'b0;
      for (int cyc = 1; cyc <= 33; cyc++) begin
         if (cyc == 3) begin
            wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFE_0005;
            iss_en = 1'b1; iss_rd = 5'd5;
         end else idle();
         #1;
         if (ready === 1'b0) zeros++;
         n_cmp++; if (ready !== (cyc >= 33)) begin n_err++; $display("FAIL init_ready cyc=%0d got %b want %b", cyc, ready, cyc >= 33); end
         if (cyc < 33) begin
            n_cmp++; if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin n_err++; $display("FAIL init_read cyc=%0d got %h/%b want 0/0", cyc, rd_data, rd_busy); end
            tick();
         end
      end
      n_cmp++; if (zeros != 32) begin n_err++; $display("FAIL init_length got %0d want 32", zeros); end
      rd_addr = {5'd5, 5'd5};
      #1;
      n_cmp++; if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin n_err++; $display("FAIL init_drop_r5 got %h/%b want 0/0", rd_data, rd_busy); end
      n_cmp++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL init_busy_vec got %h want 0", busy_vec); end
   endtask

   task automatic test_basic();
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
      tick();
      idle();
      rd_addr = {5'd7, 5'd7};
      #1;
      n_cmp++; if (rd_data[31:0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL basic_port0 got %h want deadbeef", rd_data[31:0]); end
      n_cmp++; if (rd_data[63:32] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL basic_port1 got %h want deadbeef", rd_data[63:32]); end
   endtask

   task automatic test_x0();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
      iss_en = 1'b1; iss_rd = 5'd0;
      rd_addr = {5'd0, 5'd0};
      #1;
      n_cmp++; if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin n_err++; $display("FAIL x0_same_cycle got %h/%b want 0/0", rd_data, rd_busy); end
      tick();
      idle();
      #1;
      n_cmp++; if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin n_err++; $display("FAIL x0_read got %h/%b want 0/0", rd_data, rd_busy); end
      n_cmp++; if (busy_vec[0] !== 1'b0) begin n_err++; $display("FAIL x0_busy got %b want 0", busy_vec[0]); end
   endtask

   task automatic test_scoreboard();
      logic [31:0] old;
      old = ref_mem[3];
      iss_en = 1'b1; iss_rd = 5'd3;
      tick();
      idle();
      rd_addr = {5'd0, 5'd3};
      #1;
      n_cmp++; if (busy_vec[3] !== 1'b1) begin n_err++; $display("FAIL sb_busy_t1 got %b want 1", busy_vec[3]); end
      n_cmp++; if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL sb_rd_busy_t1 got %b want 1", rd_busy[0]); end
      tick(); tick(); tick();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
      #1;
`ifdef REGFILE_BYPASS_EN
      n_cmp++; if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h55) begin n_err++; $display("FAIL sb_t4 got %b/%h want 0/55", rd_busy[0], rd_data[31:0]); end
`else
      n_cmp++; if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== old) begin n_err++; $display("FAIL sb_t4 got %b/%h want 1/%h", rd_busy[0], rd_data[31:0], old); end
`endif
      tick();
      idle();
      #1;
      n_cmp++; if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h55) begin n_err++; $display("FAIL sb_t5 got %b/%h want 0/55", rd_busy[0], rd_data[31:0]); end
   endtask

   task automatic test_simul();
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_0009;
      iss_en = 1'b1; iss_rd = 5'd9;
      tick();
      idle();
      rd_addr = {5'd9, 5'd9};
      #1;
      n_cmp++; if (busy_vec[9] !== 1'b1) begin n_err++; $display("FAIL simul_busy got %b want 1", busy_vec[9]); end
      n_cmp++; if (rd_data[31:0] !== 32'hA5A5_0009) begin n_err++; $display("FAIL simul_data got %h want a5a50009", rd_data[31:0]); end
      n_cmp++; if (rd_busy !== 2'b11) begin n_err++; $display("FAIL simul_rd_busy got %b want 11", rd_busy); end
   endtask

   task automatic test_random();
      logic [4:0] a [NRD];
      for (int n = 0; n < 400; n++) begin
         wr_en   = $urandom_range(0, 1) == 1;
         wr_addr = 5'($urandom_range(0, 31));
         wr_data = $urandom;
         iss_en  = $urandom_range(0, 2) == 0;
         iss_rd  = 5'($urandom_range(0, 31));
         for (int p = 0; p < NRD; p++)
            a[p] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         rd_addr = {a[1], a[0]};
         #1;
         for (int p = 0; p < NRD; p++) begin
            n_cmp++; if (rd_data[p*32 +: 32] !== exp_data(a[p]) || rd_busy[p] !== exp_busy(a[p])) begin
               n_err++;
               $display("FAIL rand_port%0d n=%0d addr=%0d got %h/%b want %h/%b", p, n, a[p], rd_data[p*32 +: 32], rd_busy[p], exp_data(a[p]), exp_busy(a[p]));
            end
         end
         n_cmp++; if (busy_vec !== ref_busy) begin n_err++; $display("FAIL rand_busy_vec n=%0d got %h want %h", n, busy_vec, ref_busy); end
         tick();
      end
      idle();
   endtask

   task automatic test_reset_mid();
      for (int r = 1; r < DEPTH; r++) begin
         wr_en = 1'b1; wr_addr = 5'(r); wr_data = 32'(r) * 32'h0101_0101;
         tick();
      end
      idle();
      for (int r = 8; r < 12; r++) begin
         iss_en = 1'b1; iss_rd = 5'(r);
         tick();
      end
      idle();
      #1;
      n_cmp++; if (busy_vec !== 32'h0000_0F00) begin n_err++; $display("FAIL mid_pre_busy got %h want 00000f00", busy_vec); end
      reset = 1'b1;
      tick();
      n_cmp++; if (busy_vec !== 32'h0 || ready !== 1'b0) begin n_err++; $display("FAIL mid_reset got %h/%b want 0/0", busy_vec, ready); end
      reset = 1'b0;
      for (int cyc = 1; cyc <= 33; cyc++) begin
         #1;
         n_cmp++; if (ready !== (cyc >= 33)) begin n_err++; $display("FAIL mid_sweep_ready cyc=%0d got %b want %b", cyc, ready, cyc >= 33); end
         if (cyc < 33) tick();
      end
      for (int r = 0; r < DEPTH; r++) begin
         rd_addr = {5'(DEPTH - 1 - r), 5'(r)};
         #1;
         n_cmp++; if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin n_err++; $display("FAIL mid_clear r=%0d got %h/%b want 0/0", r, rd_data, rd_busy); end
      end
   endtask

   initial begin
      for (int r = 0; r < DEPTH; r++) ref_mem[r] = '0;
      test_reset();
      test_init_sweep();
      test_basic();
      test_x0();
      test_scoreboard();
      test_simul();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file, the next generation of the single-issue pipeline regfile.
- Adds configurable width, depth and read-port count, plus a per-register pending-write scoreboard for hazard detection in decode.
- Adds a post-reset clear sequencer, so the storage array carries no reset and can map to distributed RAM.
- Sits in ID: read ports feed operand muxes, the write port is driven from WB, and the issue port marks destination registers pending.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of architectural registers; power of two, >= 2.
- NUM_RD, 2, number of independent read ports, 1..4.
- ZERO_REG, 1, when 1, entry 0 reads as zero, ignores writes and is never busy.
- AW, $clog2(DEPTH), address width; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write-back strobe.
- wr_addr  in  AW  write-back destination.
- wr_data  in  XLEN  write-back data.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i at [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data; port i at [i*XLEN +: XLEN].
- rd_busy  out  NUM_RD  port i address has a pending, unresolved write.
- iss_en  in  1  an instruction with a destination issues this cycle.
- iss_rd  in  AW  destination of the issuing instruction.
- ready  out  1  clear sweep finished; block accepts traffic.
- busy_vec  out  DEPTH  raw scoreboard state, for debug and the hazard unit.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled only on the rising edge of clk.
- Sequencer FSM has two states, INIT and RUN.
  - reset forces INIT, clr_idx=0, busy_vec=0, ready=0.
  - INIT: each cycle, mem[clr_idx] <= 0 and clr_idx increments.
  - When clr_idx==DEPTH-1, the next state is RUN and ready=1. INIT therefore lasts exactly DEPTH cycles after reset deasserts.
  - reset asserted in RUN or mid-INIT restarts INIT at index 0.
- During INIT:
  - wr_en and iss_en are ignored.
  - rd_data = 0 and rd_busy = 0.
- Write (RUN only):
  - If wr_en and not (ZERO_REG and wr_addr==0), then mem[wr_addr] <= wr_data on the clock edge.
  - The write also clears busy[wr_addr].
- Issue (RUN only):
  - If iss_en and not (ZERO_REG and iss_rd==0), then busy[iss_rd] <= 1.
  - Same cycle, same register, write and issue together: set wins (the new producer is younger), so busy stays 1 and the data is still written.
- Read: combinational from rd_addr, zero-cycle latency.
  - If ZERO_REG and rd_addr_i==0: rd_data_i=0 and rd_busy_i=0, with no bypass.
  - Otherwise rd_data_i = mem[rd_addr_i], subject to the optional bypass.
  - rd_busy_i = busy[rd_addr_i], subject to the optional bypass.
- Reset values:
  - rd_data = 0, rd_busy = 0, ready = 0, busy_vec = 0.
  - mem is undefined until the sweep completes.
- Multiple read ports on the same address return identical values.
- Issuing to an already-busy register is legal; busy stays 1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through):
  - If wr_en and wr_addr==rd_addr_i and the register is not x0 under ZERO_REG, then rd_data_i = wr_data in the same cycle.
  - In that case rd_busy_i = 0, unless iss_en targets the same register in that cycle, in which case rd_busy_i = busy before the edge, i.e. 0 via bypass.
- Undefined:
  - rd_data_i reflects mem only; a write becomes visible the cycle after wr_en.
  - rd_busy_i stays 1 through the write cycle and drops the cycle after.
  - The hazard unit must stall one extra cycle.

Decomposition:
- Package regfile_pkg holds:
  - FSM enum rf_state_e {RF_INIT, RF_RUN};
  - default XLEN/DEPTH constants;
  - localparam function for packed-port slicing offsets.
- One sub-module, regfile_scoreboard, holds the busy bits, the set/clear priority and busy_vec.
- Storage, the sequencer and the read muxes stay in regfile_mp.

Test Plan:
- Init sweep, DEPTH=32: deassert reset.
  - ready is 0 for cycles 1..32 and 1 from cycle 33.
  - A write to r5 during INIT is dropped; r5 reads 0 after ready.
- Basic write/read: wr r7=0xDEADBEEF.
  - Next cycle rd_addr0=7 gives rd_data0=0xDEADBEEF.
  - rd_addr1=7 returns the same value.
- x0 handling, ZERO_REG=1: wr r0=0x1234 and iss_rd=0.
  - Reads return 0, rd_busy=0, busy_vec[0]=0.
- Scoreboard: iss r3 at cycle t gives busy_vec[3]=1 at t+1; wr r3=0x55 at t+4.
  - With BYPASS: rd_busy=0 and rd_data=0x55 at t+4.
  - Without BYPASS: rd_busy=1 and old data at t+4; 0/0x55 at t+5.
- Simultaneous issue and write r9 in the same cycle: busy_vec[9] remains 1 and mem[9] is updated.
- Reset mid-operation: assert reset with busy_vec=0x0000_0F00 in RUN.
  - busy_vec=0 and ready=0 next cycle.
  - Full 32-cycle re-sweep; all registers read 0.
